// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer: FSM state encoding and direction codes.
package phase_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/phase_timer_next.sv
// Combinational step logic: next count value and terminal-event decode for one enabled cycle.
module phase_timer_next
    import phase_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [WIDTH-1:0] reload_val_i,
    input  logic             reload_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             term_event_o,
    output logic             go_hold_o
);

    always_comb begin
        next_count_o = count_i;
        term_event_o = 1'b0;
        go_hold_o    = 1'b0;
        if (dir_i == DIR_UP) begin
            // Only an exact match wraps early; a count above the limit rolls over naturally.
            if (count_i == limit_i) begin
                next_count_o = '0;
                term_event_o = 1'b1;
            end else begin
                next_count_o = count_i + WIDTH'(1);
            end
        end else begin
            if (count_i != '0) begin
                next_count_o = count_i - WIDTH'(1);
            end else if (reload_i) begin
                next_count_o = reload_val_i;
                term_event_o = 1'b1;
            end else begin
                term_event_o = 1'b1;
                go_hold_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Loadable up/down phase timer with modulo limit, auto-reload and a registered done pulse.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned     WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             dir_i,
    input  logic             reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_count;
    logic             term_event;
    logic             go_hold;

    phase_timer_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count_i      (count_q),
        .dir_i        (dir_i),
        .limit_i      (limit_i),
        .reload_val_i (reload_q),
        .reload_i     (reload_i),
        .next_count_o (step_count),
        .term_event_o (term_event),
        .go_hold_o    (go_hold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= RESET_VAL;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        // A load wins over counting and masks any terminal event in the same cycle.
        if (load_i) begin
            count_d  = value_i;
            reload_d = value_i;
            state_d  = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en_i) begin
                        count_d = step_count;
                        done_d  = term_event;
                        if (go_hold) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = done_q;
    assign tc_o    = (dir_i == DIR_UP) ? (count_q == limit_i) : (count_q == '0);

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: a behavioural model queues expected outputs per driven cycle.
module tb_phase_timer;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         en_i;
    logic         load_i;
    logic [W-1:0] value_i;
    logic [W-1:0] limit_i;
    logic         dir_i;
    logic         reload_i;
    logic [W-1:0] count_o;
    logic         busy_o;
    logic         tc_o;
    logic         done_o;

    typedef struct packed {
        logic [W-1:0] count;
        logic         done;
        logic         busy;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           done_seen = 0;
    logic [W-1:0] m_count;
    logic [W-1:0] m_reload;
    int           m_state;   // 0 idle, 1 run, 2 hold

    phase_timer #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .load_i   (load_i),
        .value_i  (value_i),
        .limit_i  (limit_i),
        .dir_i    (dir_i),
        .reload_i (reload_i),
        .count_o  (count_o),
        .busy_o   (busy_o),
        .tc_o     (tc_o),
        .done_o   (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = '0;
        m_reload = '0;
        m_state  = 0;
        sb.delete();
    endtask

    // Expected outputs after the coming edge, derived from the current inputs and model state.
    task automatic model_step();
        exp_t         e;
        logic [W-1:0] nc;
        logic         nd;
        int           ns;
        nc = m_count;
        nd = 1'b0;
        ns = m_state;
        if (load_i) begin
            nc       = value_i;
            m_reload = value_i;
            ns       = 1;
        end else if (m_state == 1 && en_i) begin
            if (!dir_i) begin
                if (m_count == limit_i) begin
                    nc = '0;
                    nd = 1'b1;
                end else begin
                    nc = W'(m_count + 1);
                end
            end else if (m_count != 0) begin
                nc = W'(m_count - 1);
            end else if (reload_i) begin
                nc = m_reload;
                nd = 1'b1;
            end else begin
                nd = 1'b1;
                ns = 2;
            end
        end
        m_count = nc;
        m_state = ns;
        e.count = nc;
        e.done  = nd;
        e.busy  = (ns == 1);
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("count", count_o, e.count);
        chk("done", done_o, e.done);
        chk("busy", busy_o, e.busy);
        chk("tc", tc_o, dir_i ? (e.count == 0) : (e.count == limit_i));
        if (done_o) done_seen++;
        $display("t=%0t ld=%0b v=%0d en=%0b dir=%0b rl=%0b lim=%0d -> cnt=%0d done=%0b busy=%0b tc=%0b",
                 $time, load_i, value_i, en_i, dir_i, reload_i, limit_i, count_o, done_o, busy_o, tc_o);
    endtask

    task automatic go(input logic ld, input logic [W-1:0] val, input logic en,
                      input logic dir, input logic rel, input logic [W-1:0] lim);
        load_i   = ld;
        value_i  = val;
        en_i     = en;
        dir_i    = dir;
        reload_i = rel;
        limit_i  = lim;
        cycle();
    endtask

    initial begin
        int done_at;
        rst_n    = 1'b0;
        en_i     = 1'b0;
        load_i   = 1'b0;
        value_i  = '0;
        limit_i  = 6'd5;
        dir_i    = 1'b0;
        reload_i = 1'b0;
        model_reset();
        #2;
        chk("rst_count", count_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE ignores enable
        go(0, 0, 1, 0, 0, 5);
        chk("idle_hold", count_o, 0);

        // Up wrap at limit 5
        go(1, 0, 1, 0, 0, 5);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            go(0, 0, 1, 0, 0, 5);
            chk("upwrap_seq", count_o, (i + 1) % 6);
        end
        chk("upwrap_dones", done_seen, 2);

        // Down stop into HOLD
        go(1, 3, 0, 1, 0, 5);
        for (int i = 0; i < 3; i++) go(0, 0, 1, 1, 0, 5);
        chk("down_zero", count_o, 0);
        go(0, 0, 1, 1, 0, 5);
        chk("hold_done", done_o, 1);
        chk("hold_busy", busy_o, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) go(0, 0, logic'(i % 2 == 0), 1, 0, 5);
        chk("hold_quiet", done_seen, 0);
        chk("hold_count", count_o, 0);

        // Down auto-reload, period 11, then stretched by 3 idle cycles
        go(1, 10, 0, 1, 1, 5);
        done_seen = 0;
        for (int i = 0; i < 22; i++) go(0, 0, 1, 1, 1, 5);
        chk("reload_dones", done_seen, 2);
        chk("reload_val", count_o, 10);
        done_at = -1;
        for (int i = 0; i < 14; i++) begin
            go(0, 0, logic'(!(i >= 4 && i <= 6)), 1, 1, 5);
            if (done_o && done_at < 0) done_at = i;
        end
        chk("reload_stretch", done_at, 13);

        // Zero-length phase, then load priority over a pending terminal step
        go(1, 0, 0, 1, 0, 5);
        go(0, 0, 1, 1, 0, 5);
        chk("zero_phase_done", done_o, 1);
        go(1, 0, 0, 1, 1, 5);
        go(1, 7, 1, 1, 1, 5);
        chk("load_prio_cnt", count_o, 7);
        chk("load_prio_done", done_o, 0);
        for (int i = 0; i < 8; i++) go(0, 0, 1, 1, 1, 5);
        chk("reload_reg7", count_o, 7);
        chk("reload_reg7_done", done_o, 1);

        // Wrap boundary at full range, then lowered limit
        go(1, 63, 0, 0, 0, 63);
        go(0, 0, 1, 0, 0, 63);
        chk("full_wrap", count_o, 0);
        chk("full_wrap_done", done_o, 1);
        go(1, 20, 0, 0, 0, 4);
        done_seen = 0;
        for (int i = 0; i < 49; i++) go(0, 0, 1, 0, 0, 4);
        chk("lowlim_dones", done_seen, 1);
        chk("lowlim_end", count_o, 0);

        // Limit 0: terminal event every enabled cycle
        go(1, 0, 0, 0, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) go(0, 0, 1, 0, 0, 0);
        chk("lim0_dones", done_seen, 4);

        // Random traffic checked against the model
        for (int i = 0; i < 300; i++) begin
            go(logic'($urandom_range(0, 15) == 0), W'($urandom_range(0, 20)),
               logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 1)), W'($urandom_range(0, 12)));
        end

        // Asynchronous reset while count=17 and done high
        go(1, 17, 0, 1, 1, 5);
        for (int i = 0; i < 18; i++) go(0, 0, 1, 1, 1, 5);
        chk("pre_rst_count", count_o, 17);
        chk("pre_rst_done", done_o, 1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_count", count_o, 0);
        chk("async_rst_done", done_o, 0);
        chk("async_rst_busy", busy_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        go(0, 0, 1, 1, 1, 5);
        go(1, 2, 1, 1, 1, 5);
        for (int i = 0; i < 3; i++) go(0, 0, 1, 1, 1, 5);
        chk("post_rst_reload", count_o, 2);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
